// File: rtl/alu_op_sequencer.sv
// Push-button stepped ALU operation sequencer: synchronizer, debounce, issue/wait FSM with timeout.
// Optional build macro ALU_SEQ_DIVZERO_CHECK_EN rejects DIV with a zero divisor before issue.
module alu_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [2:0]  alu_sel,
    output logic        alu_start,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        err,
    output logic [2:0]  op_code
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    logic           sync1_q, sync2_q;
    logic           db_level_q, db_level_d;
    logic           db_prev_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           press_s;

    state_t         state_q, state_d;
    logic [2:0]     op_code_q, op_code_d;
    logic [2:0]     next_code_s;
    logic [2:0]     alu_sel_q, alu_sel_d;
    logic [7:0]     alu_a_q, alu_a_d;
    logic [7:0]     alu_b_q, alu_b_d;
    logic           alu_start_q, alu_start_d;
    logic [15:0]    result_q, result_d;
    logic           result_valid_q, result_valid_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [TOW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign press_s     = db_level_q & ~db_prev_q;
    assign next_code_s = op_code_q + 3'd1;

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = sync2_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Input conditioning registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Sequencer next state; presses are only honoured in IDLE, so busy-time presses vanish.
    always_comb begin
        state_d   = state_q;
        op_code_d = op_code_q;
        alu_sel_d = alu_sel_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        result_d  = result_q;
        err_d     = err_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (press_s) begin
                    op_code_d = next_code_s;
                    if ((next_code_s != 3'd0) && (next_code_s != 3'd7)) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LATCH: begin
                alu_a_d   = op_a;
                alu_b_d   = op_b;
                alu_sel_d = op_code_q;
                err_d     = 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                if ((op_code_q == 3'd6) && (op_b == 8'd0)) begin
                    state_d  = S_ERR;
                    result_d = 16'hFFFF;
                    err_d    = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                end
`else
                state_d = S_ISSUE;
`endif
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                tmo_cnt_d = '0;
            end
            S_WAIT: begin
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = S_DONE;
                end else if (tmo_cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes and busy are registered from the next state so they line up with it.
    always_comb begin
        alu_start_d    = (state_d == S_ISSUE);
        result_valid_d = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_code_q      <= 3'd0;
            alu_sel_q      <= 3'd0;
            alu_a_q        <= 8'd0;
            alu_b_q        <= 8'd0;
            alu_start_q    <= 1'b0;
            result_q       <= 16'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            op_code_q      <= op_code_d;
            alu_sel_q      <= alu_sel_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_start_q    <= alu_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    assign alu_sel      = alu_sel_q;
    assign alu_start    = alu_start_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign op_code      = op_code_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: behavioural ALU responder plus a result scoreboard.
module tb_alu_op_sequencer;

    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn = 1'b0;
    logic [7:0]  op_a = 8'd0;
    logic [7:0]  op_b = 8'd0;
    logic [2:0]  alu_sel;
    logic        alu_start;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        err;
    logic [2:0]  op_code;

    int total = 0;
    int bad = 0;
    int alu_lat = 2;
    int alu_cnt = 0;
    int start_cnt = 0;
    int valid_cnt = 0;
    int cyc_n = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    logic err_at_start = 1'b0;
    logic [2:0] code_m = 3'd0;
    logic [15:0] exp_q[$];

    alu_op_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .btn(btn), .op_a(op_a), .op_b(op_b),
        .alu_sel(alu_sel), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .result(result),
        .result_valid(result_valid), .busy(busy), .err(err), .op_code(op_code)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] a16, b16;
        a16 = {8'd0, a};
        b16 = {8'd0, b};
        case (sel)
            3'd1: return a16 + b16;
            3'd2: return a16 - b16;
            3'd3: return a16 << b[2:0];
            3'd4: return a16 >> b[2:0];
            3'd5: return a16 * b16;
            3'd6: return (b == 8'd0) ? 16'hFFFF : a16 / b16;
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU responder and output monitor, both on the falling edge.
    always @(negedge clk) begin
        alu_done = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done = 1'b1;
                alu_result = alu_fn(alu_sel, alu_a, alu_b);
            end
        end
        if (alu_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc_n;
            err_at_start = err;
            if (alu_lat > 0) alu_cnt = alu_lat;
        end
        if (result_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("sb_result", {16'd0, result}, {16'd0, exp_q.pop_front()});
            end
        end
        cyc_n++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit bounce);
        if (bounce) begin
            for (int i = 0; i < 20; i++) begin
                if (i % 3 == 0) btn = ~btn;
                cyc();
            end
        end
        btn = 1'b1;
        repeat (DB + 6) cyc();
        btn = 1'b0;
        repeat (DB + 6) cyc();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) break;
            cyc();
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_op_code"}, {29'd0, op_code}, 32'd0);
        chk({tag, "_alu_sel"}, {29'd0, alu_sel}, 32'd0);
        chk({tag, "_alu_a"}, {24'd0, alu_a}, 32'd0);
        chk({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
        chk({tag, "_alu_start"}, {31'd0, alu_start}, 32'd0);
        chk({tag, "_result"}, {16'd0, result}, 32'd0);
        chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int lat, input bit bounce);
        int s, v;
        bit runs;
        code_m = code_m + 3'd1;
        runs = (code_m != 3'd0) && (code_m != 3'd7);
        op_a = a;
        op_b = b;
        alu_lat = lat;
        s = start_cnt;
        v = valid_cnt;
        if (runs) exp_q.push_back(alu_fn(code_m, a, b));
        press(bounce);
        wait_idle();
        chk("op_code", {29'd0, op_code}, {29'd0, code_m});
        chk("start_pulses", start_cnt - s, runs ? 32'd1 : 32'd0);
        chk("valid_pulses", valid_cnt - v, runs ? 32'd1 : 32'd0);
        if (runs) begin
            chk("alu_sel", {29'd0, alu_sel}, {29'd0, code_m});
            chk("alu_a", {24'd0, alu_a}, {24'd0, a});
            chk("alu_b", {24'd0, alu_b}, {24'd0, b});
        end
    endtask

    initial begin
        int s, v;
        logic [15:0] r0;

        repeat (3) cyc();
        check_reset_vals("reset");
        reset = 1'b0;
        cyc();

        // Single clean ADD with a two-cycle ALU
        do_op(8'd5, 8'd3, 2, 1'b0);
        chk("add_result", {16'd0, result}, 32'd8);
        chk("add_latency", valid_cyc - start_cyc, 32'd3);

        // Bouncing button, then stable: exactly one step
        do_op(8'd20, 8'd7, 2, 1'b1);

        // Walk through the remaining codes, including the no-op codes 7 and 0
        do_op(8'h81, 8'd3, 2, 1'b0);
        do_op(8'hF0, 8'd4, 3, 1'b0);
        do_op(8'd200, 8'd150, 1, 1'b0);
        do_op(8'd100, 8'd7, 2, 1'b0);
        do_op(8'd1, 8'd1, 2, 1'b0);
        do_op(8'd1, 8'd1, 2, 1'b0);

        // Second press while the first op is still waiting on the ALU
        code_m = 3'd1;
        op_a = 8'd9;
        op_b = 8'd4;
        alu_lat = 60;
        s = start_cnt;
        v = valid_cnt;
        exp_q.push_back(16'd13);
        press(1'b0);
        chk("busy_in_wait", {31'd0, busy}, 32'd1);
        press(1'b0);
        wait_idle();
        chk("drop_op_code", {29'd0, op_code}, 32'd1);
        chk("drop_starts", start_cnt - s, 32'd1);
        chk("drop_valids", valid_cnt - v, 32'd1);

        // ALU never answers: timeout to ERR, result untouched
        code_m = 3'd2;
        op_a = 8'd50;
        op_b = 8'd1;
        alu_lat = 0;
        r0 = result;
        s = start_cnt;
        v = valid_cnt;
        press(1'b0);
        wait_idle();
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_result", {16'd0, result}, {16'd0, r0});
        chk("tmo_starts", start_cnt - s, 32'd1);
        chk("tmo_valids", valid_cnt - v, 32'd0);
        repeat (10) cyc();
        chk("tmo_err_sticky", {31'd0, err}, 32'd1);
        do_op(8'd30, 8'd10, 2, 1'b0);
        chk("err_clear_at_latch", {31'd0, err_at_start}, 32'd0);
        chk("err_clear_after", {31'd0, err}, 32'd0);
        do_op(8'h80, 8'd7, 2, 1'b0);

        // Reset during WAIT of a MUL; the late alu_done must be ignored
        op_a = 8'd12;
        op_b = 8'd11;
        alu_lat = 30;
        s = start_cnt;
        btn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (start_cnt != s) break;
            cyc();
        end
        chk("mul_started", start_cnt - s, 32'd1);
        chk("mul_sel", {29'd0, alu_sel}, 32'd5);
        repeat (3) cyc();
        chk("mul_busy_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        btn = 1'b0;
        cyc();
        check_reset_vals("midop_reset");
        reset = 1'b0;
        code_m = 3'd0;
        v = valid_cnt;
        repeat (40) cyc();
        check_reset_vals("post_reset");
        chk("post_reset_valids", valid_cnt - v, 32'd0);

        // Step to DIV and divide by zero
        for (int i = 0; i < 5; i++) begin
            do_op(8'(i + 3), 8'd2, 2, 1'b0);
        end
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        code_m = 3'd6;
        op_a = 8'd50;
        op_b = 8'd0;
        alu_lat = 2;
        s = start_cnt;
        v = valid_cnt;
        press(1'b0);
        wait_idle();
        chk("dz_op_code", {29'd0, op_code}, 32'd6);
        chk("dz_starts", start_cnt - s, 32'd0);
        chk("dz_valids", valid_cnt - v, 32'd0);
        chk("dz_err", {31'd0, err}, 32'd1);
`else
        do_op(8'd50, 8'd0, 2, 1'b0);
        chk("dz_err", {31'd0, err}, 32'd0);
`endif
        chk("dz_result", {16'd0, result}, 32'h0000FFFF);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
